// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline definitions: default widths, occupancy encoding, control-bundle field offsets.
// Imported by the ID/EX register and by the downstream execute/memory stages.
package pipe_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;
    localparam int CW_DEF = 8;

    // Occupancy encoded as {main_v, skid_v}; 2'b01 has no member on purpose.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_e;

    localparam int CTRL_REG_WR_BIT = 0;
    localparam int CTRL_MEM_RD_BIT = 1;
    localparam int CTRL_MEM_WR_BIT = 2;
    localparam int CTRL_ALU_OP_LSB = 3;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_WB_SEL_BIT = 7;

    function automatic pipe_state_e pipe_state(input logic main_v, input logic skid_v);
        return pipe_state_e'({main_v, skid_v});
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register: load sets valid and captures data, clear wins over load for valid.
// Zero latency beyond the register; no flow control of its own, the owner decides load/clear.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d_dat,
    output logic         q_vld,
    output logic [W-1:0] q_dat
);
    import pipe_pkg::*;

    logic         vld_d, vld_q;
    logic [W-1:0] dat_d, dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = d_dat;
        end
        if (clr) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign q_vld = vld_q;
    assign q_dat = dat_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX register, 1-cycle latency, full throughput; ID_EX_SKID_EN adds a skid entry so InReady is a flop
// (no OutReady->InReady path); without it InReady = !MainV || OutReady. Flush/reset empty both entries.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [DW-1:0] InRD1,
    input  logic [DW-1:0] InRD2,
    input  logic [DW-1:0] InImm,
    input  logic          InALUSrc,
    input  logic [CW-1:0] InCtrl,
    input  logic [RW-1:0] InRd,
    input  logic          Flush,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] OutRD1,
    output logic [DW-1:0] OutRD2,
    output logic [DW-1:0] OutImm,
    output logic          OutALUSrc,
    output logic [CW-1:0] OutCtrl,
    output logic [RW-1:0] OutRd
);

    localparam int PW = 3*DW + 1 + CW + RW;

    logic          main_v, skid_v;
    logic          in_xfer, out_xfer;
    logic          main_load, main_clr;
    logic [PW-1:0] in_dat, main_in_dat, main_dat;

    assign in_dat   = {InRD1, InRD2, InImm, InALUSrc, InCtrl, InRd};
    assign in_xfer  = InValid && InReady;
    assign out_xfer = main_v && OutReady;

`ifdef ID_EX_SKID_EN
    logic          skid_load, skid_clr;
    logic [PW-1:0] skid_dat;

    assign InReady = !skid_v;

    // Skid refills Main first so FIFO order holds; input is never accepted while Skid is occupied.
    always_comb begin
        main_load   = 1'b0;
        main_in_dat = in_dat;
        skid_load   = 1'b0;
        skid_clr    = Flush;
        if (!Flush) begin
            if (skid_v && out_xfer) begin
                main_load   = 1'b1;
                main_in_dat = skid_dat;
                skid_clr    = 1'b1;
            end else if (in_xfer && (!main_v || out_xfer)) begin
                main_load = 1'b1;
            end else if (in_xfer) begin
                skid_load = 1'b1;
            end
        end
    end

    pipe_slot #(.W(PW)) u_skid (
        .clk   (Clk),
        .rst_n (Rst_n),
        .load  (skid_load),
        .clr   (skid_clr),
        .d_dat (in_dat),
        .q_vld (skid_v),
        .q_dat (skid_dat)
    );
`else
    assign InReady     = !main_v || OutReady;
    assign skid_v      = 1'b0;
    assign main_in_dat = in_dat;
    assign main_load   = !Flush && in_xfer;
`endif

    assign main_clr = Flush || (out_xfer && !main_load);

    pipe_slot #(.W(PW)) u_main (
        .clk   (Clk),
        .rst_n (Rst_n),
        .load  (main_load),
        .clr   (main_clr),
        .d_dat (main_in_dat),
        .q_vld (main_v),
        .q_dat (main_dat)
    );

    assign OutValid = main_v;
    assign {OutRD1, OutRD2, OutImm, OutALUSrc, OutCtrl, OutRd} = main_dat;

    pipe_state_e state;
    assign state = pipe_state(main_v, skid_v);

    a_legal_state: assert property (@(posedge Clk) disable iff (!Rst_n)
        state inside {ST_EMPTY, ST_ONE, ST_FULL});

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: queue model checked every cycle plus directed literal checks; honours ID_EX_SKID_EN.
module tb_id_ex_pipe_reg;

    logic        Clk = 1'b0;
    logic        Rst_n, InValid, InReady, InALUSrc, Flush, OutValid, OutReady, OutALUSrc;
    logic [31:0] InRD1, InRD2, InImm, OutRD1, OutRD2, OutImm;
    logic [7:0]  InCtrl, OutCtrl;
    logic [4:0]  InRd, OutRd;

    id_ex_pipe_reg dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .InRD1(InRD1), .InRD2(InRD2), .InImm(InImm), .InALUSrc(InALUSrc),
        .InCtrl(InCtrl), .InRd(InRd), .Flush(Flush), .OutValid(OutValid),
        .OutReady(OutReady), .OutRD1(OutRD1), .OutRD2(OutRD2), .OutImm(OutImm),
        .OutALUSrc(OutALUSrc), .OutCtrl(OutCtrl), .OutRd(OutRd)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic        alu;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
    } pl_t;

`ifdef ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    pl_t mq[$];
    bit  zero_data = 1'b0;
    bit  started   = 1'b0;
    int  n_checks  = 0;
    int  n_fail    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit model_ir();
        if (CAP == 2) return mq.size() < 2;
        return mq.size() == 0 || OutReady;
    endfunction

    // Model: a FIFO of capacity CAP; reset/flush empty it, pop on output transfer, push on input transfer.
    always @(posedge Clk) begin
        bit ir, ox, ix;
        pl_t p;
        if (!Rst_n) begin
            mq.delete();
            zero_data = 1'b1;
        end else if (Flush) begin
            mq.delete();
        end else begin
            ir = model_ir();
            ox = (mq.size() > 0) && OutReady;
            ix = InValid && ir;
            if (ox) void'(mq.pop_front());
            if (ix) begin
                p.rd1 = InRD1; p.rd2 = InRD2; p.imm = InImm;
                p.alu = InALUSrc; p.ctrl = InCtrl; p.rd = InRd;
                mq.push_back(p);
                zero_data = 1'b0;
            end
        end
        started = 1'b1;
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("m_out_valid", 64'(OutValid), 64'(mq.size() > 0));
            chk("m_in_ready", 64'(InReady), 64'(model_ir()));
            if (mq.size() > 0) begin
                chk("m_rd1", 64'(OutRD1), 64'(mq[0].rd1));
                chk("m_rd2", 64'(OutRD2), 64'(mq[0].rd2));
                chk("m_imm", 64'(OutImm), 64'(mq[0].imm));
                chk("m_alusrc", 64'(OutALUSrc), 64'(mq[0].alu));
                chk("m_ctrl", 64'(OutCtrl), 64'(mq[0].ctrl));
                chk("m_rd", 64'(OutRd), 64'(mq[0].rd));
            end else if (zero_data) begin
                chk("m_zero_data", {OutRD1, OutImm}, 64'd0);
                chk("m_zero_ctl", 64'({OutRD2[15:0], OutALUSrc, OutCtrl, OutRd}), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] k);
        InValid  = 1'b1;
        InRD1    = k;
        InRD2    = k ^ 32'h5a5a_0000;
        InImm    = k + 32'h200;
        InALUSrc = k[0];
        InCtrl   = k[7:0] ^ 8'h3c;
        InRd     = k[4:0];
    endtask

    initial begin
        Rst_n = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        put_word(32'h0); InValid = 1'b0;
        tick(); tick();
        Rst_n = 1'b1;
        chk("reset_out_valid", 64'(OutValid), 64'd0);
        chk("reset_in_ready", 64'(InReady), 64'd1);
        chk("reset_rd1", 64'(OutRD1), 64'd0);

        // first transfer
        put_word(32'h0); InRD1 = 32'h11; InImm = 32'h22; InALUSrc = 1'b1; OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        chk("t1_out_valid", 64'(OutValid), 64'd1);
        chk("t1_imm", 64'(OutImm), 64'h22);
        chk("t1_alusrc", 64'(OutALUSrc), 64'd1);
        chk("t1_in_ready", 64'(InReady), 64'd1);
        tick();

        // back-to-back stream
        for (int k = 1; k <= 4; k++) begin
            put_word(32'(k));
            tick();
            chk("stream_rd1", 64'(OutRD1), 64'(k));
            chk("stream_valid", 64'(OutValid), 64'd1);
        end
        InValid = 1'b0;
        tick();

        // stall handling
        OutReady = 1'b0;
        put_word(32'hA);
        tick();
`ifdef ID_EX_SKID_EN
        put_word(32'hB);
        tick();
        InValid = 1'b0;
        chk("full_in_ready", 64'(InReady), 64'd0);
        chk("full_holds_a", 64'(OutRD1), 64'hA);
        OutReady = 1'b1;
        tick();
        chk("drain_b", 64'(OutRD1), 64'hB);
        chk("drain_in_ready", 64'(InReady), 64'd1);
`else
        chk("noskid_in_ready_low", 64'(InReady), 64'd0);
        put_word(32'hB);
        OutReady = 1'b1;
        #1;
        chk("noskid_in_ready_pass", 64'(InReady), 64'd1);
        tick();
        InValid = 1'b0;
        chk("pass_b", 64'(OutRD1), 64'hB);
`endif
        tick();
        chk("drained", 64'(OutValid), 64'd0);

        // flush with an input offered in the same cycle
        OutReady = 1'b0;
        put_word(32'hC1);
        tick();
`ifdef ID_EX_SKID_EN
        put_word(32'hC2);
        tick();
`endif
        put_word(32'hCC); Flush = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b0;
        chk("flush_out_valid", 64'(OutValid), 64'd0);
        chk("flush_in_ready", 64'(InReady), 64'd1);
        OutReady = 1'b1;
        repeat (3) tick();

        // reset while holding, with flush also asserted
        OutReady = 1'b0;
        put_word(32'h55);
        tick();
        InValid = 1'b0; Rst_n = 1'b0; Flush = 1'b1;
        tick();
        chk("rst_out_valid", 64'(OutValid), 64'd0);
        chk("rst_data", {OutRD1, OutImm}, 64'd0);
        chk("rst_ctrl", 64'(OutCtrl), 64'd0);
        Rst_n = 1'b1; Flush = 1'b0;
        tick();

        // mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            put_word($urandom);
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            Flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
